ysyx_25030093_ifu: RTL and testbench

//  Instruction fetch unit: the consumer of the PC register's output.
//  - Accepts a fetch address from the PC stage over valid/ready.
//  - Issues one AXI4-Lite read (AR/R channels) per address.
//  - Presents the returned instruction to decode over valid/ready.
//  - One outstanding fetch at a time. A redirect flush discards in-flight work.

---
 rtl/ysyx_25030093_pkg.sv | 6 +
 rtl/ysyx_25030093_ifu_perf.sv | 26 ++
 rtl/ysyx_25030093_ifu.sv | 111 +++++++++++
 tb/tb_ysyx_25030093_ifu.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030093_pkg.sv
// ysyx_25030093_pkg: shared state encoding and constants for the instruction fetch unit.
package ysyx_25030093_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} ifu_state_t;
    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [31:0] INST_NOP      = 32'h0000_0013;
endpackage

// File: rtl/ysyx_25030093_ifu_perf.sv
// ysyx_25030093_ifu_perf: 64-bit wrapping fetch and stall counters.
module ysyx_25030093_ifu_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  logic        stall,
    output logic [63:0] fetch_cnt,
    output logic [63:0] stall_cnt
);
    logic [63:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {63'd0, fetch};
        stall_cnt_d = stall_cnt_q + {63'd0, stall};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: rtl/ysyx_25030093_ifu.sv
// ysyx_25030093_ifu: single-outstanding AXI4-Lite instruction fetch with redirect flush.
// Define IFU_PERF_CNT_EN to add the perf_fetch_cnt/perf_stall_cnt counters.
module ysyx_25030093_ifu
    import ysyx_25030093_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(INST_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    output logic              inst_valid,
    input  logic              inst_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt
`endif
);
    ifu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d, inst_pc_q, inst_pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              fault_q, fault_d, drop_q, drop_d;

    assign pc_ready   = (state_q == IDLE) && !flush;
    assign arvalid    = state_q == REQ;
    assign rready     = (state_q == WAIT) || (state_q == DROP);
    assign inst_valid = state_q == HOLD;
    assign inst       = inst_valid ? inst_q : NOP;
    assign inst_fault = inst_valid && fault_q;
    assign araddr     = araddr_q;
    assign inst_pc    = inst_pc_q;

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        inst_pc_d = inst_pc_q;
        inst_d    = inst_q;
        fault_d   = fault_q;
        drop_d    = drop_q;
        unique case (state_q)
            IDLE: if (pc_valid && pc_ready) begin
                araddr_d  = pc_in;
                inst_pc_d = pc_in;
                drop_d    = 1'b0;
                state_d   = REQ;
            end
            // The AR request cannot be withdrawn, so a flush here only marks the response for discard.
            REQ: begin
                drop_d = drop_q || flush;
                if (arready) begin
                    state_d = (drop_q || flush) ? DROP : WAIT;
                    drop_d  = 1'b0;
                end
            end
            WAIT: if (rvalid) begin
                state_d = flush ? IDLE : HOLD;
                inst_d  = rdata;
                fault_d = rresp != AXI_RESP_OKAY;
            end else if (flush) begin
                state_d = DROP;
            end
            HOLD: state_d = (flush || inst_ready) ? IDLE : HOLD;
            DROP: state_d = rvalid ? IDLE : DROP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            araddr_q  <= '0;
            inst_pc_q <= '0;
            inst_q    <= NOP;
            fault_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            inst_pc_q <= inst_pc_d;
            inst_q    <= inst_d;
            fault_q   <= fault_d;
            drop_q    <= drop_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    ysyx_25030093_ifu_perf u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch     (inst_valid && inst_ready),
        .stall     ((state_q == REQ) || (state_q == WAIT) || (state_q == DROP)),
        .fetch_cnt (perf_fetch_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`endif
endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// tb_ysyx_25030093_ifu: directed scenarios plus random traffic checked against a transaction-level model.
module tb_ysyx_25030093_ifu;
    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] pc_in = '0, rdata = '0;
    logic        pc_valid = 1'b0, flush = 1'b0, arready = 1'b0, rvalid = 1'b0, inst_ready = 1'b0;
    logic [1:0]  rresp = '0;
    logic        pc_ready, arvalid, rready, inst_fault, inst_valid;
    logic [31:0] araddr, inst, inst_pc;
    int          total = 0, bad = 0;

    // Model: a fetch is "busy" from acceptance until delivered or discarded.
    logic        m_busy, m_ar, m_doom, m_have, m_fault;
    logic [31:0] m_addr, m_inst;

    ysyx_25030093_ifu dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
        .inst_valid(inst_valid), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", n, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ar = 0; m_doom = 0; m_have = 0; m_fault = 0;
        m_addr = '0; m_inst = '0;
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (pc_valid && !flush) begin
                m_busy = 1; m_ar = 0; m_doom = 0; m_have = 0; m_addr = pc_in;
            end
        end else if (!m_ar) begin
            if (flush) m_doom = 1;
            if (arready) m_ar = 1;
        end else if (!m_have) begin
            if (rvalid) begin
                if (m_doom || flush) m_busy = 0;
                else begin m_have = 1; m_inst = rdata; m_fault = rresp != 2'b00; end
            end else if (flush) m_doom = 1;
        end else if (flush || inst_ready) begin
            m_busy = 0; m_have = 0;
        end
    endtask

    task automatic compare_all();
        chk("pc_ready",   64'(pc_ready),   64'(!m_busy && !flush));
        chk("arvalid",    64'(arvalid),    64'(m_busy && !m_ar));
        chk("araddr",     64'(araddr),     64'(m_addr));
        chk("rready",     64'(rready),     64'(m_busy && m_ar && !m_have));
        chk("inst_valid", 64'(inst_valid), 64'(m_have));
        chk("inst",       64'(inst),       64'(m_have ? m_inst : 32'h0000_0013));
        chk("inst_pc",    64'(inst_pc),    64'(m_addr));
        chk("inst_fault", 64'(inst_fault), 64'(m_have && m_fault));
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        // 1: idle after reset
        repeat (3) cyc();
        chk("t1_arvalid", 64'(arvalid), 64'h0);
        chk("t1_inst_valid", 64'(inst_valid), 64'h0);
        chk("t1_inst", 64'(inst), 64'h13);
        chk("t1_pc_ready", 64'(pc_ready), 64'h1);
        // 2: zero-wait fetch, inst_valid three edges after acceptance
        pc_valid = 1; pc_in = 32'h8000_0000; arready = 1; rvalid = 1; rdata = 32'h0010_0093; rresp = 0;
        cyc();
        pc_valid = 0;
        cyc();
        chk("t2_early_valid", 64'(inst_valid), 64'h0);
        cyc();
        chk("t2_inst_valid", 64'(inst_valid), 64'h1);
        chk("t2_inst", 64'(inst), 64'h0010_0093);
        chk("t2_inst_pc", 64'(inst_pc), 64'h8000_0000);
        chk("t2_fault", 64'(inst_fault), 64'h0);
        rvalid = 0; arready = 0; inst_ready = 1;
        cyc();
        chk("t2_back_idle", 64'(pc_ready), 64'h1);
        // 3: arready held low
        inst_ready = 0; pc_valid = 1; pc_in = 32'h8000_0004;
        cyc();
        pc_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_arvalid", 64'(arvalid), 64'h1);
            chk("t3_araddr", 64'(araddr), 64'h8000_0004);
            chk("t3_pc_ready", 64'(pc_ready), 64'h0);
            cyc();
        end
        arready = 1;
        cyc();
        chk("t3_wait_pc_ready", 64'(pc_ready), 64'h0);
        chk("t3_wait_arvalid", 64'(arvalid), 64'h0);
        arready = 0; rvalid = 1; rdata = 32'h0020_0113;
        cyc();
        rvalid = 0; inst_ready = 1;
        cyc();
        chk("t3_idle", 64'(pc_ready), 64'h1);
        // 4: flush while waiting for data
        inst_ready = 0; pc_valid = 1; pc_in = 32'h8000_0008; arready = 1;
        cyc();
        pc_valid = 0;
        cyc();
        arready = 0; flush = 1;
        cyc();
        flush = 0;
        for (int i = 0; i < 2; i++) begin
            chk("t4_drop_rready", 64'(rready), 64'h1);
            chk("t4_drop_valid", 64'(inst_valid), 64'h0);
            chk("t4_drop_pc_ready", 64'(pc_ready), 64'h0);
            cyc();
        end
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        cyc();
        chk("t4_discard_valid", 64'(inst_valid), 64'h0);
        chk("t4_discard_idle", 64'(pc_ready), 64'h1);
        rvalid = 0; pc_valid = 1; pc_in = 32'h8000_000C;
        cyc();
        chk("t4_next_arvalid", 64'(arvalid), 64'h1);
        chk("t4_next_araddr", 64'(araddr), 64'h8000_000C);
        // 5: error response still delivers
        pc_valid = 0; arready = 1;
        cyc();
        arready = 0; rvalid = 1; rresp = 2'b10; rdata = 32'h0000_0073;
        cyc();
        chk("t5_valid", 64'(inst_valid), 64'h1);
        chk("t5_fault", 64'(inst_fault), 64'h1);
        chk("t5_inst", 64'(inst), 64'h73);
        chk("t5_inst_pc", 64'(inst_pc), 64'h8000_000C);
        rvalid = 0; rresp = 0; inst_ready = 1;
        cyc();
        chk("t5_idle_valid", 64'(inst_valid), 64'h0);
        chk("t5_idle_inst", 64'(inst), 64'h13);
        chk("t5_idle_ready", 64'(pc_ready), 64'h1);
        // 6: stall in HOLD then asynchronous reset
        inst_ready = 0; pc_valid = 1; pc_in = 32'h8000_0010; arready = 1; rvalid = 1; rdata = 32'h1234_5678;
        cyc();
        pc_valid = 0;
        repeat (2) cyc();
        rvalid = 0; arready = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t6_hold_valid", 64'(inst_valid), 64'h1);
            chk("t6_hold_inst", 64'(inst), 64'h1234_5678);
            cyc();
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("t6_arvalid", 64'(arvalid), 64'h0);
        chk("t6_rready", 64'(rready), 64'h0);
        chk("t6_inst_valid", 64'(inst_valid), 64'h0);
        chk("t6_inst", 64'(inst), 64'h13);
        chk("t6_inst_pc", 64'(inst_pc), 64'h0);
        chk("t6_fault", 64'(inst_fault), 64'h0);
        chk("t6_araddr", 64'(araddr), 64'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            pc_valid   = ($urandom % 3) != 0;
            pc_in      = $urandom;
            flush      = ($urandom % 10) == 0;
            arready    = ($urandom % 2) == 1;
            rvalid     = ($urandom % 2) == 1;
            rdata      = $urandom;
            rresp      = 2'(($urandom % 4 == 0) ? $urandom % 4 : 0);
            inst_ready = ($urandom % 3) != 0;
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
